ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
Sequences accesses to the 32-entry single-port RAM and shares it between two requesters, for example the APB slave datapath and a debug/DMA port. Each requester uses a simple req/ack handshake. The block grants one transaction at a time using round-robin arbitration. It drives the RAM's enable/we/addr/data_in and captures data_out for reads.

Parameters:
ADDRESS_WIDTH, 5, width of requester and RAM address (32 entries)
DATA_WIDTH, 32, width of write/read data

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
req0  input  1  requester 0 transaction request, held until ack0
we0  input  1  requester 0: 1=write, 0=read
addr0  input  ADDRESS_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 write data
ack0  output  1  one-cycle completion pulse to requester 0
rdata0  output  DATA_WIDTH  requester 0 read data, valid with ack0 and held afterwards
req1, we1, addr1, wdata1, ack1, rdata1  as above for requester 1
ram_enable  output  1  RAM enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDRESS_WIDTH  RAM address
ram_data_in  output  DATA_WIDTH  RAM write data
ram_data_out  input  DATA_WIDTH  RAM registered read data, valid 1 cycle after read enable
busy  output  1  high whenever the FSM is not IDLE
grant_id  output  1  requester owning the current transaction; valid while busy

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=IDLE; all outputs 0 (ack*, rdata*, ram_*, busy, grant_id).
  - last_grant=1, so requester 0 wins the first tie.
  - Any in-flight transaction is abandoned: no ack is issued. RAM contents are not touched.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE (cycle T): requests are sampled only here.
  - Only one req high: grant it.
  - Both high: grant the requester != last_grant.
  - On grant: latch we/addr/wdata into ram_we/ram_addr/ram_data_in; set ram_enable=1, grant_id, last_grant, busy=1; go to ACCESS.
  - No req: stay in IDLE, ram_enable=0, ram_we=0.
- ACCESS (T+1): ram_enable=1 for exactly this one cycle; the RAM samples at the end of T+1.
  - Write: go to RESP with ackN=1 for requester N.
  - Read: go to CAPTURE.
  - ram_enable and ram_we clear at the end of T+1.
- CAPTURE (T+2, reads only): rdataN <= ram_data_out; set ackN=1; go to RESP.
- RESP: ackN is high during this cycle (write ack at T+2, read ack at T+3); busy=1.
  - Next cycle: ack=0, busy=0, state=IDLE.
  - A req still high at that IDLE starts a new transaction (minimum spacing: write 3 cycles, read 4 cycles).
- Requester rules:
  - The requester must hold req and its fields stable until the latch cycle. Changes after the latch are ignored.
  - The requester may keep req high after ack to issue back-to-back transactions.
  - A req that drops before grant is simply not served.
- rdataN changes only on a completed read for requester N. The other requester's rdata is unaffected. Writes never change rdata.
- ram_addr and ram_data_in hold their last values when idle. ram_we is 0 when ram_enable is 0.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1. A requester never waits more than one foreign transaction.
- RST during any state: the next cycle is IDLE with all outputs 0. A write abandoned in ACCESS may already have been sampled by the RAM. This is acceptable and no ack is issued.

Test Plan:
- Hold RST=1 for 2 cycles, then release -> all outputs 0, busy=0; with no req, ram_enable never asserts.
- req0 write addr=5 wdata=0xDEADBEEF at T -> ram_enable=1,ram_we=1,ram_addr=5,ram_data_in=0xDEADBEEF only at T+1; ack0 pulse at T+2; then req0 read addr=5 -> ack0 at T'+3 with rdata0=0xDEADBEEF.
- req0 and req1 asserted same cycle after reset, both held, all reads -> grant_id sequence 0,1,0,1; ack0/ack1 alternate with no lost or duplicated acks.
- req0 writes 0x12345678 to addr 3, then req1 reads addr 3 -> rdata1=0x12345678 at ack1; rdata0 keeps its prior value.
- req0 changes addr from 7 to 9 during ACCESS -> ram_addr stays 7; transaction completes on addr 7.
- RST asserted during ACCESS of a req1 write -> no ack1; next cycle ram_enable=0, busy=0; afterwards simultaneous req0/req1 -> requester 0 granted first.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing a single-port registered-read RAM between two
// req/ack requesters; one transaction in flight at a time, all outputs registered.
module ram_access_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  output logic                     ack0,
  output logic [DATA_WIDTH-1:0]    rdata0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     ack1,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     ram_enable,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out,
  output logic                     busy,
  output logic                     grant_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic                     grant_id_q, grant_id_d;
  logic                     busy_q, busy_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0]    rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]    rdata1_q, rdata1_d;
  logic                     ram_enable_q, ram_enable_d;
  logic                     ram_we_q, ram_we_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]    ram_data_in_q, ram_data_in_d;
  logic                     gnt;

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_id_q    <= 1'b0;
      busy_q        <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      ram_enable_q  <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      ram_enable_q  <= ram_enable_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
    end
  end

  // Next-state logic; acks and RAM strobes are single-cycle by default
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    busy_d        = busy_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    ram_enable_d  = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    gnt           = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes next
          gnt           = (req0 && req1) ? ~last_grant_q : req1;
          state_d       = ACCESS;
          ram_enable_d  = 1'b1;
          ram_we_d      = gnt ? we1 : we0;
          ram_addr_d    = gnt ? addr1 : addr0;
          ram_data_in_d = gnt ? wdata1 : wdata0;
          grant_id_d    = gnt;
          last_grant_d  = gnt;
          busy_d        = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (ram_we_q) begin
          state_d = RESP;
          ack0_d  = ~grant_id_q;
          ack1_d  = grant_id_q;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = RESP;
        if (grant_id_q) begin
          rdata1_d = ram_data_out;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = ram_data_out;
          ack0_d   = 1'b1;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign ram_enable  = ram_enable_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 32x32 registered-read RAM.
module tb_ram_access_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        ram_enable, ram_we;
  logic [4:0]  ram_addr;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out = 32'h0;
  logic        busy, grant_id;
  logic [31:0] mem [32];

  int n_vec = 0;
  int n_err = 0;

  ram_access_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_enable(ram_enable), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 CLK = ~CLK;

  // Single-port RAM, read data registered one cycle after enable
  always @(posedge CLK) begin
    if (ram_enable) begin
      if (ram_we) mem[ram_addr] <= ram_data_in;
      else        ram_data_out  <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one transaction from an idle cycle and return cycles until its ack
  task automatic txn(input bit port, input bit we, input logic [4:0] addr,
                     input logic [31:0] data, output int lat);
    lat = 0;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data; end
    do begin
      tick();
      lat++;
      req0 = 1'b0;
      req1 = 1'b0;
    end while (!(port ? ack1 : ack0) && lat < 10);
    chk("txn_other_ack", {31'd0, port ? ack0 : ack1}, 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    RST = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = 5'd0; wdata0 = 32'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 5'd0; wdata1 = 32'd0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_ram", {ram_enable, ram_we, ram_addr, 25'd0}, 32'd0);
    chk("rst_ram_din", ram_data_in, 32'd0);
    chk("rst_busy_gid", {30'd0, busy, grant_id}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_no_enable", {30'd0, ram_enable, busy}, 32'd0);
    end

    // Write 0xDEADBEEF to addr 5: strobe only at T+1, ack at T+2
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    tick();
    req0 = 1'b0;
    chk("wr_en", {30'd0, ram_enable, ram_we}, 32'd3);
    chk("wr_addr", {27'd0, ram_addr}, 32'd5);
    chk("wr_din", ram_data_in, 32'hDEADBEEF);
    chk("wr_busy_gid", {30'd0, busy, grant_id}, 32'd2);
    chk("wr_ack_early", {31'd0, ack0}, 32'd0);
    tick();
    chk("wr_ack", {31'd0, ack0}, 32'd1);
    chk("wr_en_clr", {30'd0, ram_enable, ram_we}, 32'd0);
    tick();
    chk("wr_done", {30'd0, ack0, busy}, 32'd0);
    chk("wr_hold_addr", {27'd0, ram_addr}, 32'd5);

    // Read back addr 5: ack at T+3 with data
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
    tick();
    req0 = 1'b0;
    chk("rd_en", {30'd0, ram_enable, ram_we}, 32'd2);
    tick();
    chk("rd_no_ack_t2", {31'd0, ack0}, 32'd0);
    tick();
    chk("rd_ack", {31'd0, ack0}, 32'd1);
    chk("rd_data", rdata0, 32'hDEADBEEF);
    tick();
    chk("rd_done", {30'd0, ack0, busy}, 32'd0);
    chk("rd_hold", rdata0, 32'hDEADBEEF);

    // Fresh reset, then both requesters hold reads: grants alternate starting at 0
    RST = 1'b1; tick(); RST = 1'b0;
    chk("rst2_rdata0", rdata0, 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_grant", {31'd0, grant_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick(); tick();
      chk("rr_ack0", {31'd0, ack0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ack1", {31'd0, ack1}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      chk("rr_ack_clr", {30'd0, ack0, ack1}, 32'd0);
    end
    tick();
    chk("rr_idle", {31'd0, busy}, 32'd0);
    chk("rr_rdata1", rdata1, 32'hDEADBEEF);

    // req0 writes addr 3, req1 reads it back; rdata0 untouched
    txn(1'b0, 1'b1, 5'd3, 32'h12345678, lat);
    chk("wr_latency", lat, 32'd2);
    txn(1'b1, 1'b0, 5'd3, 32'h0, lat);
    chk("rd_latency", lat, 32'd3);
    chk("x_rdata1", rdata1, 32'h12345678);
    chk("x_rdata0", rdata0, 32'hDEADBEEF);

    // Address change after the latch is ignored
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 32'hAAAA5555;
    tick();
    req0 = 1'b0; addr0 = 5'd9; wdata0 = 32'h99999999;
    chk("late_addr", {27'd0, ram_addr}, 32'd7);
    chk("late_din", ram_data_in, 32'hAAAA5555);
    tick();
    chk("late_ack", {31'd0, ack0}, 32'd1);
    tick();
    txn(1'b1, 1'b0, 5'd7, 32'h0, lat);
    chk("late_readback", rdata1, 32'hAAAA5555);

    // Reset during a req1 write ACCESS abandons it
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd10; wdata1 = 32'h0BADF00D;
    tick();
    chk("ab_access", {30'd0, ram_enable, grant_id}, 32'd3);
    RST = 1'b1; req1 = 1'b0;
    tick();
    RST = 1'b0;
    chk("ab_state", {29'd0, ram_enable, busy, ack1}, 32'd0);
    chk("ab_rdata1", rdata1, 32'd0);
    tick();
    chk("ab_no_late_ack", {30'd0, ack1, busy}, 32'd0);

    // After reset a tie goes to requester 0, then requester 1
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd3;
    tick();
    chk("post_rst_grant0", {31'd0, grant_id}, 32'd0);
    tick(); tick();
    chk("post_rst_ack0", {31'd0, ack0}, 32'd1);
    chk("post_rst_rdata0", rdata0, 32'h12345678);
    tick();
    req0 = 1'b0;
    tick();
    req1 = 1'b0;
    chk("post_rst_grant1", {30'd0, busy, grant_id}, 32'd3);
    tick(); tick();
    chk("post_rst_ack1", {31'd0, ack1}, 32'd1);
    chk("post_rst_rdata1", rdata1, 32'h12345678);
    chk("post_rst_rdata0_keep", rdata0, 32'h12345678);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
